// File: rtl/vliw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vliw_pkg
// Description : Shared constants for the two-slot VLIW issue logic: register
//               index width, latency classes and the hardwired-zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package vliw_pkg;

  localparam int REG_W   = 5;

  // Bubbles a dependent bundle needs behind each producer class
  localparam int LAT_ALU = 0;
  localparam int LAT_LD  = 1;
  localparam int LAT_MUL = 2;

  // r0 reads as zero and is never tracked
  localparam logic [REG_W-1:0] R0 = '0;

  function automatic logic is_tracked(input logic [REG_W-1:0] r);
    return r != R0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_countdown.sv
`default_nettype none
// ============================================================================
// Module      : reg_countdown
// Description : Per-register countdown of cycles until an in-flight result
//               becomes forwardable. Load wins over decrement, flush wins over
//               everything; the count stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_countdown #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          flush,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] r_cnt;

  // Flush clears, an issued write reloads, otherwise count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : Issue-stage interlock for the two-slot VLIW pipeline. Stalls a
//               decoding bundle whose sources are not yet forwardable or whose
//               destinations would become forwardable before an older write.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard
  import vliw_pkg::*;
#(
  parameter int NREG = 32,
  parameter int CW   = 2,
  parameter int SCW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bnd_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rsc,
  input  logic [REG_W-1:0] rd0,
  input  logic [REG_W-1:0] rdc,
  input  logic             wr0,
  input  logic             wrc,
  input  logic [CW-1:0]    lat0,
  input  logic [CW-1:0]    latc,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic             waw_err,
  output logic [SCW-1:0]   stall_cycles,
  output logic             busy_any
);

  logic [CW-1:0]  w_cnt [NREG];
  logic           w_raw;
  logic           w_waw;
  logic           w_stall;
  logic           w_issue;
  logic           r_waw_err;
  logic [SCW-1:0] r_stall_cycles;

  assign w_cnt[0] = '0;

  // One countdown per tracked register; slot c wins a same-bundle collision
  generate
    for (genvar r = 1; r < NREG; r++) begin : g_reg
      logic          w_hit0;
      logic          w_hitc;
      logic [CW-1:0] w_val;

      assign w_hit0 = wr0 && (rd0 == REG_W'(r));
      assign w_hitc = wrc && (rdc == REG_W'(r));
      assign w_val  = w_hitc ? latc : lat0;

      reg_countdown #(
        .CW (CW)
      ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_issue && (w_hit0 || w_hitc)),
        .load_val (w_val),
        .flush    (flush),
        .cnt      (w_cnt[r])
      );
    end
  endgenerate

  // Hazard detection against the current countdowns; r0 never hazards
  always_comb begin
    w_raw = (is_tracked(rs1) && (w_cnt[rs1] != '0))
         || (is_tracked(rs2) && (w_cnt[rs2] != '0))
         || (is_tracked(rsc) && (w_cnt[rsc] != '0));
    w_waw = (wr0 && is_tracked(rd0) && (w_cnt[rd0] > lat0))
         || (wrc && is_tracked(rdc) && (w_cnt[rdc] > latc));
    w_stall = bnd_valid && !flush && (w_raw || w_waw);
    w_issue = bnd_valid && !w_stall;
  end

  // Any register still counting down
  always_comb begin
    busy_any = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      busy_any = busy_any | (w_cnt[r] != '0);
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Sticky flag for an issued bundle writing one register from both slots;
  // a flushed bundle is already dead downstream and does not count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waw_err <= 1'b0;
    end else if (w_issue && !flush && wr0 && wrc && (rd0 == rdc) && is_tracked(rd0)) begin
      r_waw_err <= 1'b1;
    end
  end

  assign stall        = w_stall;
  assign issue        = w_issue;
  assign waw_err      = r_waw_err;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scoreboard
// Description : Self-checking bench for issue_scoreboard. A reference model of
//               per-register "cycles until forwardable" predicts each cycle's
//               outputs into a queue; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

  logic        clk;
  logic        rst;
  logic        bnd_valid;
  logic [4:0]  rs1, rs2, rsc, rd0, rdc;
  logic        wr0, wrc;
  logic [1:0]  lat0, latc;
  logic        flush;
  logic        stall, issue, waw_err, busy_any;
  logic [15:0] stall_cycles;

  typedef struct {
    logic       bv;
    logic [4:0] rs1, rs2, rsc, rd0, rdc;
    logic       wr0, wrc;
    logic [1:0] lat0, latc;
    logic       flush;
  } bnd_t;

  typedef struct {
    logic stall;
    logic issue;
    logic busy;
    logic waw;
    int   sc;
  } exp_t;

  exp_t q[$];
  int   m_cnt [32];
  int   m_sc;
  bit   m_waw;
  int   checks;
  int   errors;

  issue_scoreboard #(
    .NREG (32),
    .CW   (2),
    .SCW  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bnd_valid    (bnd_valid),
    .rs1          (rs1),
    .rs2          (rs2),
    .rsc          (rsc),
    .rd0          (rd0),
    .rdc          (rdc),
    .wr0          (wr0),
    .wrc          (wrc),
    .lat0         (lat0),
    .latc         (latc),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .waw_err      (waw_err),
    .stall_cycles (stall_cycles),
    .busy_any     (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT against the oldest prediction mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",        int'(stall),        int'(e.stall));
      chk("issue",        int'(issue),        int'(e.issue));
      chk("busy_any",     int'(busy_any),     int'(e.busy));
      chk("waw_err",      int'(waw_err),      int'(e.waw));
      chk("stall_cycles", int'(stall_cycles), e.sc);
    end
  end

  function automatic bnd_t nop();
    bnd_t b;
    b.bv = 1'b0; b.rs1 = '0; b.rs2 = '0; b.rsc = '0; b.rd0 = '0; b.rdc = '0;
    b.wr0 = 1'b0; b.wrc = 1'b0; b.lat0 = '0; b.latc = '0; b.flush = 1'b0;
    return b;
  endfunction

  function automatic bnd_t rdr(input int s1, input int s2, input int sc);
    bnd_t b;
    b = nop();
    b.bv = 1'b1; b.rs1 = 5'(s1); b.rs2 = 5'(s2); b.rsc = 5'(sc);
    return b;
  endfunction

  function automatic bnd_t wr(input bit c, input int rd, input int lat);
    bnd_t b;
    b = nop();
    b.bv = 1'b1;
    if (c) begin b.wrc = 1'b1; b.rdc = 5'(rd); b.latc = 2'(lat); end
    else   begin b.wr0 = 1'b1; b.rd0 = 5'(rd); b.lat0 = 2'(lat); end
    return b;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endfunction

  // Present one bundle for one cycle: predict, wait for the edge, advance model
  task automatic apply(input bnd_t b);
    exp_t e;
    bit   hz;
    bit   any;
    bnd_valid = b.bv; rs1 = b.rs1; rs2 = b.rs2; rsc = b.rsc;
    rd0 = b.rd0; rdc = b.rdc; wr0 = b.wr0; wrc = b.wrc;
    lat0 = b.lat0; latc = b.latc; flush = b.flush;

    hz = 1'b0;
    if (b.rs1 != 0 && m_cnt[b.rs1] > 0) hz = 1'b1;
    if (b.rs2 != 0 && m_cnt[b.rs2] > 0) hz = 1'b1;
    if (b.rsc != 0 && m_cnt[b.rsc] > 0) hz = 1'b1;
    if (b.wr0 && b.rd0 != 0 && m_cnt[b.rd0] > int'(b.lat0)) hz = 1'b1;
    if (b.wrc && b.rdc != 0 && m_cnt[b.rdc] > int'(b.latc)) hz = 1'b1;
    any = 1'b0;
    for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) any = 1'b1;

    e.stall = b.bv && !b.flush && hz;
    e.issue = b.bv && !e.stall;
    e.busy  = any;
    e.waw   = m_waw;
    e.sc    = m_sc;
    q.push_back(e);

    @(posedge clk);
    if (e.stall && m_sc < 65535) m_sc++;
    for (int r = 1; r < 32; r++) begin
      if (b.flush) m_cnt[r] = 0;
      else if (m_cnt[r] > 0) m_cnt[r]--;
    end
    if (!b.flush && e.issue) begin
      if (b.wr0 && b.rd0 != 0) m_cnt[b.rd0] = int'(b.lat0);
      if (b.wrc && b.rdc != 0) m_cnt[b.rdc] = int'(b.latc);
      if (b.wr0 && b.wrc && b.rd0 == b.rdc && b.rd0 != 0) m_waw = 1'b1;
    end
    #1;
  endtask

  initial begin
    bnd_t b;
    checks = 0; errors = 0; m_sc = 0; m_waw = 1'b0;
    model_clear();
    rst = 1'b1;
    bnd_valid = 1'b0; rs1 = '0; rs2 = '0; rsc = '0; rd0 = '0; rdc = '0;
    wr0 = 1'b0; wrc = 1'b0; lat0 = '0; latc = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle and an independent reader
    apply(nop());
    apply(rdr(3, 0, 0));

    // Load r5 then reader via rs2: one stall cycle
    apply(wr(1'b0, 5, 1));
    apply(rdr(0, 5, 0));
    apply(rdr(0, 5, 0));

    // Mul r7 on slot c then reader via rsc: two stall cycles
    apply(wr(1'b1, 7, 2));
    repeat (3) apply(rdr(0, 0, 7));
    // Same producer, r0 reader never stalls
    apply(wr(1'b1, 7, 2));
    apply(rdr(0, 0, 0));
    repeat (2) apply(nop());

    // Mul r9 then ALU rewrite of r9: WAW stalls until the mul is forwardable
    apply(wr(1'b0, 9, 2));
    repeat (3) apply(wr(1'b0, 9, 0));
    apply(rdr(9, 0, 0));

    // Same-bundle double write of r4: slot c (lat 0) wins, flag set
    b = wr(1'b0, 4, 2);
    b.wrc = 1'b1; b.rdc = 5'd4; b.latc = 2'd0;
    apply(b);
    apply(rdr(4, 4, 4));
    apply(nop());

    // Load r6 then a flushed reader: no stall, tracking discarded
    apply(wr(1'b0, 6, 1));
    b = rdr(6, 0, 0);
    b.flush = 1'b1;
    apply(b);
    apply(rdr(6, 0, 0));

    // Max latency producer, then asynchronous reset mid-countdown
    apply(wr(1'b1, 10, 3));
    apply(nop());
    @(negedge clk);
    #1;
    bnd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_stall",        int'(stall),        0);
    chk("rst_issue",        int'(issue),        0);
    chk("rst_waw_err",      int'(waw_err),      0);
    chk("rst_stall_cycles", int'(stall_cycles), 0);
    chk("rst_busy_any",     int'(busy_any),     0);
    model_clear();
    m_sc = 0;
    m_waw = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    apply(rdr(10, 0, 10));

    // Randomized bundles over a small register window to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      b.bv    = ($urandom_range(0, 9) < 8);
      b.rs1   = 5'($urandom_range(0, 7));
      b.rs2   = 5'($urandom_range(0, 7));
      b.rsc   = 5'($urandom_range(0, 7));
      b.rd0   = 5'($urandom_range(0, 7));
      b.rdc   = 5'($urandom_range(0, 7));
      b.wr0   = 1'($urandom_range(0, 1));
      b.wrc   = 1'($urandom_range(0, 1));
      b.lat0  = 2'($urandom_range(0, 3));
      b.latc  = 2'($urandom_range(0, 3));
      b.flush = ($urandom_range(0, 31) == 0);
      apply(b);
    end
    apply(nop());

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-stage interlock for the two-slot VLIW pipeline: main slot 0 and companion slot c. It tracks, per architectural register, how many cycles remain until an in-flight result can be bypassed by the forwarding network. When a decoding bundle's source would read a value not yet forwardable, it stalls the bundle. It sits beside decode: it consumes the bundle's sources and destinations and drives the stall that freezes the fetch/decode registers.

## Interface
Parameters:
- NREG, 32, number of architectural registers (r0 hardwired zero, never tracked)
- CW, 2, width of per-register countdown and of latency inputs
- SCW, 16, width of the saturating stall-cycle counter

Clock and reset:
- One clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset

Ports:
- bnd_valid  in  1  a bundle is presented at decode this cycle
- rs1, rs2  in  5  slot-0 source registers
- rsc  in  5  slot-c source register
- rd0, rdc  in  5  slot-0 and slot-c destination registers
- wr0, wrc  in  1  slot-0 and slot-c write enables
- lat0, latc  in  CW  bubbles a dependent bundle needs (ALU 0, load 1, mul 2)
- flush  in  1  pipeline redirect; discards all in-flight tracking
- stall  out  1  hold decode; bundle not issued this cycle
- issue  out  1  bnd_valid & ~stall
- waw_err  out  1  sticky: bundle with wr0&wrc&rd0==rdc!=0 was issued
- stall_cycles  out  SCW  saturating count of cycles with stall=1
- busy_any  out  1  some register countdown nonzero

## Operation
- State: cnt[r], CW bits, r=1..NREG-1; cnt[0] is constant 0.
- RAW hazard:
  - slot-0 sources: raw = (rs1!=0 & cnt[rs1]!=0) | (rs2!=0 & cnt[rs2]!=0)
  - slot-c source: rsc!=0 & cnt[rsc]!=0
- WAW hazard: wr0 & rd0!=0 & cnt[rd0]>lat0, and the same for slot c. A younger write must not become forwardable before an older one.
- stall = bnd_valid & ~flush & (raw | waw).
- Per-register update at each clock edge, in priority order:
  - flush: cnt <= 0.
  - issue & wrc & rdc==r: cnt <= latc. Slot c wins a same-bundle collision and waw_err is set.
  - issue & wr0 & rd0==r: cnt <= lat0.
  - cnt!=0: cnt <= cnt-1.
  - else hold.
- Destinations with lat=0 write 0, so that register never stalls a consumer (pure ALU back-to-back forwarding).
- A source equal to a same-bundle destination is not a hazard; intra-bundle dependences are resolved by the compiler.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- waw_err is cleared only by rst.

## Timing
- stall, issue and busy_any are combinational from the current cnt values and inputs; there is no registered stall.
- A producer issued at cycle t with lat=L makes a dependent bundle at t+1 stall for exactly L cycles; the dependent bundle issues at t+1+L.
- Reset: all cnt=0, stall=0, issue=0 (bnd_valid low), waw_err=0, stall_cycles=0, busy_any=0.
- Reset mid-operation discards all tracking immediately and asynchronously.
- flush in the same cycle as a bundle: stall forced to 0, issue follows bnd_valid, and no cnt is written. The flushed bundle is treated as already killed downstream.
- A stalled bundle updates no state except the decrements; the bundle is re-evaluated the next cycle.
- CW bounds latency: lat input values above 2^CW-1 are not representable. The maximum is 3 with the default CW.

## Structure
- Shared package vliw_pkg:
  - REG_W=5
  - latency class constants LAT_ALU=0, LAT_LD=1, LAT_MUL=2
  - r0 index constant
- Sub-module reg_countdown, one instance per register:
  - inputs: load, load value, flush
  - output: cnt
  - implements the decrement/saturation rule
- Top level owns hazard compare, slot priority, stall counter and the error flag.

## Test plan
- Reset then bundle rs1=3 with no producers -> stall=0, issue=1, stall_cycles=0.
- Load r5 with lat0=1 at t, bundle rs2=5 at t+1 -> stall=1 at t+1 only, issue at t+2, stall_cycles=1.
- Mul r7 with latc=2 at t, bundle rsc=7 at t+1 -> stall at t+1 and t+2, issue at t+3. Repeat with rs1=0 (r0) -> never stall.
- Mul r9 lat=2 at t, ALU write r9 lat=0 at t+1 -> WAW stall at t+1 and t+2. The ALU write issues at t+3, and cnt[9] ends at 0.
- Same bundle wr0=wrc=1, rd0=rdc=4, lat0=2, latc=0 -> waw_err=1 sticky, cnt[4]=0 (slot c wins), the next reader of r4 does not stall.
- Load r6 lat=1, then flush with bundle rs1=6 next cycle -> stall=0, busy_any=0 after the edge. Assert rst mid-countdown -> all outputs at reset values immediately.
